// File: rtl/fme7_reg_writer.sv
// -----------------------------------------------------------------------------
// fme7_reg_writer
//
// Bus-initiator sequencer for a Sunsoft FME-7 style mapper register file.
// One {reg, data} request is turned into two ordered, ce-qualified PRG bus
// writes:
//   1. a command write to CMD_ADDR carrying {4'b0, reg}, which selects the index
//   2. a parameter write to DATA_ADDR carrying data, which loads that register
// An optional idle gap of GAP_CYCLES ce-cycles may follow each write.
//
// Ports:
//   clk        system clock
//   reset_n    asynchronous active-low reset
//   ce         CPU-cycle enable; bus writes complete on a clk edge with ce=1
//   req_valid  request present
//   req_ready  request accepted when req_valid & req_ready
//   req_reg    target register index (0..15)
//   req_data   value to write
//   bus_ain    address to PRG bus
//   bus_dout   write data to PRG bus
//   bus_write  write strobe to PRG bus
//   busy       sequence in progress
//   done       one-clk pulse when the parameter write completes
//
// Optional feature (macro FME7_CMD_SKIP_EN):
//   Keeps a shadow of the last completed command index. A request whose index
//   matches a valid shadow skips the command write and goes straight to the
//   parameter write. Without the macro every request issues a command write.
//
// CMD_ADDR[15:13] must be 3'b100 and DATA_ADDR[15:13] must be 3'b101 for the
// mapper to decode the writes. GAP_CYCLES must be in 0..15.
// -----------------------------------------------------------------------------
module fme7_reg_writer #(
    parameter logic [15:0] CMD_ADDR   = 16'h8000,
    parameter logic [15:0] DATA_ADDR  = 16'hA000,
    parameter int          GAP_CYCLES = 0
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        ce,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [3:0]  req_reg,
    input  logic [7:0]  req_data,
    output logic [15:0] bus_ain,
    output logic [7:0]  bus_dout,
    output logic        bus_write,
    output logic        busy,
    output logic        done
);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        CMD      = 3'd1,
        CMD_GAP  = 3'd2,
        DATA     = 3'd3,
        DATA_GAP = 3'd4
    } state_t;

    localparam logic [3:0] GAP_LD = 4'(GAP_CYCLES);

    state_t      state_q,     state_d;
    logic        req_ready_q, req_ready_d;
    logic        busy_q,      busy_d;
    logic        done_q,      done_d;
    logic        bus_write_q, bus_write_d;
    logic [15:0] bus_ain_q,   bus_ain_d;
    logic [7:0]  bus_dout_q,  bus_dout_d;
    logic [3:0]  reg_q,       reg_d;
    logic [7:0]  data_q,      data_d;
    logic [3:0]  gap_q,       gap_d;
`ifdef FME7_CMD_SKIP_EN
    logic [3:0]  shadow_q,     shadow_d;
    logic        shadow_vld_q, shadow_vld_d;
`endif

    always_comb begin
        state_d     = state_q;
        req_ready_d = req_ready_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        bus_write_d = bus_write_q;
        bus_ain_d   = bus_ain_q;
        bus_dout_d  = bus_dout_q;
        reg_d       = reg_q;
        data_d      = data_q;
        gap_d       = gap_q;
`ifdef FME7_CMD_SKIP_EN
        shadow_d     = shadow_q;
        shadow_vld_d = shadow_vld_q;
`endif

        case (state_q)
            IDLE: begin
                if (!busy_q) begin
                    // Waiting: capture the request so req_* may change afterwards.
                    if (req_valid && req_ready_q) begin
                        reg_d       = req_reg;
                        data_d      = req_data;
                        req_ready_d = 1'b0;
                        busy_d      = 1'b1;
                    end
                end else if (ce) begin
                    // Request latched on the previous edge: launch the first write.
`ifdef FME7_CMD_SKIP_EN
                    if (shadow_vld_q && (shadow_q == reg_q)) begin
                        state_d     = DATA;
                        bus_write_d = 1'b1;
                        bus_ain_d   = DATA_ADDR;
                        bus_dout_d  = data_q;
                    end else begin
                        state_d     = CMD;
                        bus_write_d = 1'b1;
                        bus_ain_d   = CMD_ADDR;
                        bus_dout_d  = {4'b0000, reg_q};
                    end
`else
                    state_d     = CMD;
                    bus_write_d = 1'b1;
                    bus_ain_d   = CMD_ADDR;
                    bus_dout_d  = {4'b0000, reg_q};
`endif
                end
            end

            CMD: begin
                if (ce) begin
`ifdef FME7_CMD_SKIP_EN
                    shadow_d     = reg_q;
                    shadow_vld_d = 1'b1;
`endif
                    if (GAP_CYCLES > 0) begin
                        // Address and data hold through the gap; only the strobe drops.
                        state_d     = CMD_GAP;
                        bus_write_d = 1'b0;
                        gap_d       = GAP_LD;
                    end else begin
                        state_d     = DATA;
                        bus_write_d = 1'b1;
                        bus_ain_d   = DATA_ADDR;
                        bus_dout_d  = data_q;
                    end
                end
            end

            CMD_GAP: begin
                if (ce) begin
                    if (gap_q <= 4'd1) begin
                        state_d     = DATA;
                        bus_write_d = 1'b1;
                        bus_ain_d   = DATA_ADDR;
                        bus_dout_d  = data_q;
                        gap_d       = 4'd0;
                    end else begin
                        gap_d = gap_q - 4'd1;
                    end
                end
            end

            DATA: begin
                if (ce) begin
                    done_d      = 1'b1;
                    bus_write_d = 1'b0;
                    if (GAP_CYCLES > 0) begin
                        state_d = DATA_GAP;
                        gap_d   = GAP_LD;
                    end else begin
                        state_d     = IDLE;
                        req_ready_d = 1'b1;
                        busy_d      = 1'b0;
                    end
                end
            end

            DATA_GAP: begin
                if (ce) begin
                    if (gap_q <= 4'd1) begin
                        state_d     = IDLE;
                        req_ready_d = 1'b1;
                        busy_d      = 1'b0;
                        gap_d       = 4'd0;
                    end else begin
                        gap_d = gap_q - 4'd1;
                    end
                end
            end

            default: begin
                state_d     = IDLE;
                req_ready_d = 1'b1;
                busy_d      = 1'b0;
                bus_write_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            req_ready_q <= 1'b1;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            bus_write_q <= 1'b0;
            bus_ain_q   <= 16'h0000;
            bus_dout_q  <= 8'h00;
            reg_q       <= 4'h0;
            data_q      <= 8'h00;
            gap_q       <= 4'h0;
`ifdef FME7_CMD_SKIP_EN
            shadow_q     <= 4'h0;
            shadow_vld_q <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            req_ready_q <= req_ready_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            bus_write_q <= bus_write_d;
            bus_ain_q   <= bus_ain_d;
            bus_dout_q  <= bus_dout_d;
            reg_q       <= reg_d;
            data_q      <= data_d;
            gap_q       <= gap_d;
`ifdef FME7_CMD_SKIP_EN
            shadow_q     <= shadow_d;
            shadow_vld_q <= shadow_vld_d;
`endif
        end
    end

    assign req_ready = req_ready_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign bus_write = bus_write_q;
    assign bus_ain   = bus_ain_q;
    assign bus_dout  = bus_dout_q;

endmodule

// File: tb/tb_fme7_reg_writer.sv
// -----------------------------------------------------------------------------
// tb_fme7_reg_writer
//
// Directed bench for fme7_reg_writer. Two instances share clk, reset_n and ce:
// dut0 with GAP_CYCLES=0 and dut2 with GAP_CYCLES=2. Completed bus writes
// ({ain, dout} on an edge with bus_write & ce) are logged per instance and one
// line is printed per write.
// -----------------------------------------------------------------------------
module tb_fme7_reg_writer;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        ce;

    logic        v0, rdy0, wr0, busy0, done0;
    logic [3:0]  r0;
    logic [7:0]  d0, dout0;
    logic [15:0] ain0;

    logic        v2, rdy2, wr2, busy2, done2;
    logic [3:0]  r2;
    logic [7:0]  d2, dout2;
    logic [15:0] ain2;

    int n_checks = 0;
    int n_pass   = 0;

    logic [23:0] log0[$];
    logic [23:0] log2[$];

    always #5 clk = ~clk;

    fme7_reg_writer #(.CMD_ADDR(16'h8000), .DATA_ADDR(16'hA000), .GAP_CYCLES(0)) dut0 (
        .clk(clk), .reset_n(reset_n), .ce(ce),
        .req_valid(v0), .req_ready(rdy0), .req_reg(r0), .req_data(d0),
        .bus_ain(ain0), .bus_dout(dout0), .bus_write(wr0),
        .busy(busy0), .done(done0)
    );

    fme7_reg_writer #(.CMD_ADDR(16'h8000), .DATA_ADDR(16'hA000), .GAP_CYCLES(2)) dut2 (
        .clk(clk), .reset_n(reset_n), .ce(ce),
        .req_valid(v2), .req_ready(rdy2), .req_reg(r2), .req_data(d2),
        .bus_ain(ain2), .bus_dout(dout2), .bus_write(wr2),
        .busy(busy2), .done(done2)
    );

    // Inputs change #1 after posedge, so at negedge the values are exactly
    // what the next posedge will see.
    always @(negedge clk) begin
        if (reset_n && ce) begin
            if (wr0) begin
                log0.push_back({ain0, dout0});
                $display("dut0 bus write ain=%h dout=%h", ain0, dout0);
            end
            if (wr2) begin
                log2.push_back({ain2, dout2});
                $display("dut2 bus write ain=%h dout=%h", ain2, dout2);
            end
        end
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp)
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        else
            n_pass++;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [23:0] get0(input int i);
        return (i < log0.size()) ? log0[i] : 24'hFFFFFF;
    endfunction

    function automatic logic [23:0] get2(input int i);
        return (i < log2.size()) ? log2[i] : 24'hFFFFFF;
    endfunction

    // Issue one request and wait for the sequence to finish (bounded).
    task automatic run_req(input bit sel, input logic [3:0] r, input logic [7:0] d);
        bit acc = 1'b0;
        int n = 0;
        if (sel) begin r2 = r; d2 = d; v2 = 1'b1; end
        else     begin r0 = r; d0 = d; v0 = 1'b1; end
        while (n < 50 && !(acc && !(sel ? busy2 : busy0))) begin
            if (sel ? (v2 && rdy2) : (v0 && rdy0)) acc = 1'b1;
            tick();
            n++;
            if (acc) begin v0 = 1'b0; v2 = 1'b0; end
        end
        check_val("req_accepted", {31'b0, acc}, 32'd1);
        check_val("req_busy_end", {31'b0, (sel ? busy2 : busy0)}, 32'd0);
    endtask

    task automatic pulse_reset();
        reset_n = 1'b0;
        tick();
        tick();
        reset_n = 1'b1;
        tick();
    endtask

    initial begin : main
        logic [23:0] exp_q[$];
        int acc_e[2];
        int wr_e[$];
        int n_acc;
        int done_cnt;
        bit hold_ok;
        bit acc;
        logic pw, pce;
        logic [15:0] pa;
        logic gap_wr;
        logic [15:0] gap_ain;

        reset_n = 1'b1;
        ce = 1'b1;
        v0 = 1'b0; r0 = 4'h0; d0 = 8'h00;
        v2 = 1'b0; r2 = 4'h0; d2 = 8'h00;
        gap_wr = 1'b1; gap_ain = 16'h0;

        // ---------------- reset values ----------------
        #2 reset_n = 1'b0;
        #1;
        check_val("rst_ready", {31'b0, rdy0}, 32'd1);
        check_val("rst_write", {31'b0, wr0}, 32'd0);
        check_val("rst_ain", {16'b0, ain0}, 32'h0000);
        check_val("rst_dout", {24'b0, dout0}, 32'h00);
        check_val("rst_busy", {31'b0, busy0}, 32'd0);
        check_val("rst_done", {31'b0, done0}, 32'd0);
        tick();
        tick();
        reset_n = 1'b1;
        tick();

        // ---------------- 1: single request, ce=1, GAP=0 ----------------
        log0.delete();
        r0 = 4'hD; d0 = 8'h81; v0 = 1'b1;
        check_val("t1_ready_pre", {31'b0, rdy0}, 32'd1);
        tick();                                   // accept edge N
        v0 = 1'b0; r0 = 4'h2; d0 = 8'h55;         // may change freely now
        check_val("t1_busy_acc", {31'b0, busy0}, 32'd1);
        check_val("t1_ready_acc", {31'b0, rdy0}, 32'd0);
        check_val("t1_write_acc", {31'b0, wr0}, 32'd0);
        tick();                                   // N+1: command write
        check_val("t1_cmd_wr", {31'b0, wr0}, 32'd1);
        check_val("t1_cmd_ain", {16'b0, ain0}, 32'h8000);
        check_val("t1_cmd_dout", {24'b0, dout0}, 32'h0D);
        tick();                                   // N+2: parameter write
        check_val("t1_dat_wr", {31'b0, wr0}, 32'd1);
        check_val("t1_dat_ain", {16'b0, ain0}, 32'hA000);
        check_val("t1_dat_dout", {24'b0, dout0}, 32'h81);
        check_val("t1_done_early", {31'b0, done0}, 32'd0);
        tick();                                   // N+3
        check_val("t1_done", {31'b0, done0}, 32'd1);
        check_val("t1_wr_end", {31'b0, wr0}, 32'd0);
        check_val("t1_busy_end", {31'b0, busy0}, 32'd0);
        check_val("t1_ready_end", {31'b0, rdy0}, 32'd1);
        tick();
        check_val("t1_done_clr", {31'b0, done0}, 32'd0);
        check_val("t1_nwrites", log0.size(), 32'd2);

        // ---------------- 2: ce 1-of-3 ----------------
        log0.delete();
        r0 = 4'h8; d0 = 8'h1F; v0 = 1'b1;
        done_cnt = 0; hold_ok = 1'b1; acc = 1'b0;
        for (int k = 0; k < 60; k++) begin
            ce = (k % 3 == 0);
            pw = wr0; pa = ain0; pce = ce;
            if (v0 && rdy0) acc = 1'b1;
            tick();
            if (acc) v0 = 1'b0;
            if (pw && !pce && (!wr0 || ain0 != pa)) hold_ok = 1'b0;
            if (done0) done_cnt++;
        end
        ce = 1'b1;
        check_val("t2_hold", {31'b0, hold_ok}, 32'd1);
        check_val("t2_done_cnt", done_cnt, 32'd1);
        check_val("t2_nwrites", log0.size(), 32'd2);
        check_val("t2_w0", {8'b0, get0(0)}, 32'h800008);
        check_val("t2_w1", {8'b0, get0(1)}, 32'hA0001F);
        check_val("t2_busy_end", {31'b0, busy0}, 32'd0);

        // ---------------- 3: GAP=2, two queued requests ----------------
        log2.delete();
        r2 = 4'h0; d2 = 8'h12; v2 = 1'b1;
        n_acc = 0; acc_e[0] = -1; acc_e[1] = -1;
        for (int k = 0; k < 40; k++) begin
            if (v2 && rdy2 && n_acc < 2) begin acc_e[n_acc] = k; n_acc++; end
            if (wr2 && ce) wr_e.push_back(k);
            if (k == 3) begin gap_wr = wr2; gap_ain = ain2; end
            tick();
            if (n_acc == 1) begin r2 = 4'h1; d2 = 8'h34; end
            else if (n_acc == 2) v2 = 1'b0;
        end
        check_val("t3_nacc", n_acc, 32'd2);
        check_val("t3_acc0", acc_e[0], 32'd0);
        check_val("t3_acc_gap", acc_e[1] - acc_e[0], 32'd8);
        check_val("t3_gap_wr", {31'b0, gap_wr}, 32'd0);
        check_val("t3_gap_ain", {16'b0, gap_ain}, 32'h8000);
        check_val("t3_nwr", wr_e.size(), 32'd4);
        for (int i = 0; i < 4; i++) begin
            int expe[4] = '{2, 5, 10, 13};
            check_val($sformatf("t3_wr_edge%0d", i), (i < wr_e.size()) ? wr_e[i] : -1, expe[i]);
        end
        check_val("t3_w0", {8'b0, get2(0)}, 32'h800000);
        check_val("t3_w1", {8'b0, get2(1)}, 32'hA00012);
        check_val("t3_w2", {8'b0, get2(2)}, 32'h800001);
        check_val("t3_w3", {8'b0, get2(3)}, 32'hA00034);

        // ---------------- 4: reset mid-sequence ----------------
        log2.delete();
        r2 = 4'h5; d2 = 8'h66; v2 = 1'b1;
        tick();                                   // accept
        v2 = 1'b0;
        tick();                                   // command write on bus
        tick();                                   // command done, now in gap
        check_val("t4_gap_wr", {31'b0, wr2}, 32'd0);
        reset_n = 1'b0;
        #1;
        check_val("t4_rst_wr", {31'b0, wr2}, 32'd0);
        check_val("t4_rst_busy", {31'b0, busy2}, 32'd0);
        check_val("t4_rst_ain", {16'b0, ain2}, 32'h0000);
        tick();
        tick();
        reset_n = 1'b1;
        repeat (12) tick();
        check_val("t4_nwrites", log2.size(), 32'd1);
        check_val("t4_w0", {8'b0, get2(0)}, 32'h800005);
        check_val("t4_ready", {31'b0, rdy2}, 32'd1);
        check_val("t4_busy", {31'b0, busy2}, 32'd0);

        // reset while the command strobe is high
        log0.delete();
        r0 = 4'h3; d0 = 8'h77; v0 = 1'b1;
        tick();
        v0 = 1'b0;
        tick();
        check_val("t4b_cmd_wr", {31'b0, wr0}, 32'd1);
        reset_n = 1'b0;
        #1;
        check_val("t4b_rst_wr", {31'b0, wr0}, 32'd0);
        tick();
        reset_n = 1'b1;
        repeat (8) tick();
        check_val("t4b_nwrites", log0.size(), 32'd0);
        check_val("t4b_ready", {31'b0, rdy0}, 32'd1);

        // ---------------- 5: same register twice ----------------
        pulse_reset();
        log0.delete();
        run_req(1'b0, 4'hE, 8'hAA);
        run_req(1'b0, 4'hE, 8'hBB);
`ifdef FME7_CMD_SKIP_EN
        check_val("t5_nwrites", log0.size(), 32'd3);
        check_val("t5_w0", {8'b0, get0(0)}, 32'h80000E);
        check_val("t5_w1", {8'b0, get0(1)}, 32'hA000AA);
        check_val("t5_w2", {8'b0, get0(2)}, 32'hA000BB);
`else
        check_val("t5_nwrites", log0.size(), 32'd4);
        check_val("t5_w0", {8'b0, get0(0)}, 32'h80000E);
        check_val("t5_w1", {8'b0, get0(1)}, 32'hA000AA);
        check_val("t5_w2", {8'b0, get0(2)}, 32'h80000E);
        check_val("t5_w3", {8'b0, get0(3)}, 32'hA000BB);
`endif
        pulse_reset();
        log0.delete();
        run_req(1'b0, 4'hE, 8'hCC);
        check_val("t5r_nwrites", log0.size(), 32'd2);
        check_val("t5r_w0", {8'b0, get0(0)}, 32'h80000E);
        check_val("t5r_w1", {8'b0, get0(1)}, 32'hA000CC);

        // ---------------- 6: req_valid held, inputs changing ----------------
        pulse_reset();
        log0.delete();
        v0 = 1'b1;
        for (int k = 0; k < 12; k++) begin
            r0 = 4'(k);
            d0 = 8'h40 + 8'(k);
            if (v0 && rdy0) begin
                exp_q.push_back({16'h8000, 4'h0, 4'(k)});
                exp_q.push_back({16'hA000, 8'h40 + 8'(k)});
            end
            tick();
        end
        v0 = 1'b0;
        for (int k = 0; k < 20 && busy0; k++) tick();
        check_val("t6_busy_end", {31'b0, busy0}, 32'd0);
        check_val("t6_nwrites", log0.size(), exp_q.size());
        check_val("t6_some", {31'b0, (exp_q.size() >= 4)}, 32'd1);
        for (int i = 0; i < exp_q.size(); i++)
            check_val($sformatf("t6_w%0d", i), {8'b0, get0(i)}, {8'b0, exp_q[i]});

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
